tx_order_arb: RTL and testbench

Round-robin arbiter that shares the single outbound order link between NUM_STOCKS per-stock strategy channels. Each channel raises a buy/sell order request. The arbiter grants one channel at a time, latches that channel's price and volume, and emits one `tx_dv` pulse tagged with the stock address. It sits downstream of the per-stock strategy units fed by the receive demux, and upstream of the order transmitter, which provides `tx_busy` backpressure.

---
 rtl/hft_pkg.sv | 21 ++
 rtl/tx_order_arb_if.sv | 29 ++
 rtl/tx_order_arb_rr_pick.sv | 27 ++
 rtl/tx_order_arb.sv | 135 +++++++++++++
 tb/tb_tx_order_arb.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hft_pkg.sv
// Shared definitions for the order-path blocks: side encoding, default payload
// widths and the arbiter state encoding.
package hft_pkg;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  localparam int PRICE_W_DEF = 32;
  localparam int VOL_W_DEF   = 32;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SEND_ENC = 2'd1;
  localparam logic [1:0] ST_GAP_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_GAP  = ST_GAP_ENC
  } arb_state_t;

endpackage

// File: rtl/tx_order_arb_if.sv
// Request/grant and outbound-order bundle between the strategy channels, the
// arbiter and the transmitter. The arbiter uses the slave modport.
interface tx_order_arb_if #(
  parameter int NUM_STOCKS = 4,
  parameter int PRICE_W    = 32,
  parameter int VOL_W      = 32
);
  logic [NUM_STOCKS-1:0]         req_valid;
  logic [NUM_STOCKS-1:0]         req_side;
  logic [NUM_STOCKS*PRICE_W-1:0] req_price;
  logic [NUM_STOCKS*VOL_W-1:0]   req_vol;
  logic [NUM_STOCKS-1:0]         req_ready;
  logic                          tx_busy;
  logic [7:0]                    tx_addr;
  logic                          tx_side;
  logic [PRICE_W-1:0]            tx_price;
  logic [VOL_W-1:0]              tx_vol;
  logic                          tx_dv;

  modport slave (
    input  req_valid, req_side, req_price, req_vol, tx_busy,
    output req_ready, tx_addr, tx_side, tx_price, tx_vol, tx_dv
  );

  modport master (
    output req_valid, req_side, req_price, req_vol, tx_busy,
    input  req_ready, tx_addr, tx_side, tx_price, tx_vol, tx_dv
  );
endinterface

// File: rtl/tx_order_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after
// i_last_grant, wrapping modulo N. Reusable by any arbiter.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_req
);

  int w_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_winner = i_last_grant;
    w_idx    = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx    = (int'(i_last_grant) + k) % N;
      o_winner = i_req[w_idx] ? IDX_W'(w_idx) : o_winner;
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/tx_order_arb.sv
// Round-robin arbiter sharing the outbound order link between NUM_STOCKS
// strategy channels. Optional gap throttling via TX_ARB_THROTTLE_EN.
module tx_order_arb
  import hft_pkg::*;
#(
  parameter int NUM_STOCKS = 4,
  parameter int PRICE_W    = PRICE_W_DEF,
  parameter int VOL_W      = VOL_W_DEF,
  parameter int MIN_GAP    = 4
) (
  input logic             clk,
  input logic             reset_n,
  tx_order_arb_if.slave   bus
);

  localparam int IDX_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [IDX_W-1:0]       r_last_grant;
  logic [IDX_W-1:0]       w_winner;
  logic                   w_any_req;
  logic                   w_grant;
  logic                   w_gap_done;
  logic [NUM_STOCKS-1:0]  w_onehot;

  logic [NUM_STOCKS-1:0]  r_req_ready;
  logic                   r_tx_dv;
  logic [7:0]             r_tx_addr;
  logic                   r_tx_side;
  logic [PRICE_W-1:0]     r_tx_price;
  logic [VOL_W-1:0]       r_tx_vol;

  rr_pick #(.N(NUM_STOCKS), .IDX_W(IDX_W)) u_pick (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

`ifdef TX_ARB_THROTTLE_EN
  logic [7:0] r_gap_cnt;

  // Gap counter: loaded on grant, the SEND cycle is its first decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_cnt <= 8'd0;
    end else if (w_grant) begin
      r_gap_cnt <= 8'(MIN_GAP);
    end else if (r_gap_cnt != 8'd0) begin
      r_gap_cnt <= r_gap_cnt - 8'd1;
    end else begin
      r_gap_cnt <= r_gap_cnt;
    end
  end

  assign w_gap_done = (r_gap_cnt == 8'd0);
`else
  assign w_gap_done = 1'b1;
`endif

  // Next-state and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req && !bus.tx_busy) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (!bus.tx_busy && w_gap_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One-hot acknowledge for the current winner.
  always_comb begin
    w_onehot = {NUM_STOCKS{1'b0}};
    for (int i = 0; i < NUM_STOCKS; i++) begin
      w_onehot[i] = (IDX_W'(i) == w_winner);
    end
  end

  // State and round-robin pointer; reset gives channel 0 first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDX_W'(NUM_STOCKS - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_grant ? w_winner : r_last_grant;
    end
  end

  // Strobes last exactly one cycle; payload holds until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_dv     <= 1'b0;
      r_req_ready <= {NUM_STOCKS{1'b0}};
      r_tx_addr   <= 8'd0;
      r_tx_side   <= 1'b0;
      r_tx_price  <= {PRICE_W{1'b0}};
      r_tx_vol    <= {VOL_W{1'b0}};
    end else if (w_grant) begin
      r_tx_dv     <= 1'b1;
      r_req_ready <= w_onehot;
      r_tx_addr   <= 8'(w_winner);
      r_tx_side   <= bus.req_side[w_winner];
      r_tx_price  <= bus.req_price[w_winner*PRICE_W +: PRICE_W];
      r_tx_vol    <= bus.req_vol[w_winner*VOL_W +: VOL_W];
    end else begin
      r_tx_dv     <= 1'b0;
      r_req_ready <= {NUM_STOCKS{1'b0}};
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.tx_dv     = r_tx_dv;
  assign bus.tx_addr   = r_tx_addr;
  assign bus.tx_side   = r_tx_side;
  assign bus.tx_price  = r_tx_price;
  assign bus.tx_vol    = r_tx_vol;

endmodule

// File: tb/tb_tx_order_arb.sv
// Directed and randomized bench for tx_order_arb against a cycle-rule model
// of the arbiter (grant windows from edge arithmetic, round-robin by search).
module tb_tx_order_arb;
  import hft_pkg::*;

  localparam int N       = 4;
  localparam int PW      = 32;
  localparam int VW      = 32;
  localparam int MIN_GAP = 4;
`ifdef TX_ARB_THROTTLE_EN
  localparam int EXIT_MIN = (MIN_GAP + 1 > 2) ? MIN_GAP + 1 : 2;
`else
  localparam int EXIT_MIN = 2;
`endif
  localparam int SPACING = EXIT_MIN + 1;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  tx_order_arb_if #(.NUM_STOCKS(N), .PRICE_W(PW), .VOL_W(VW)) bus ();

  tx_order_arb #(.NUM_STOCKS(N), .PRICE_W(PW), .VOL_W(VW), .MIN_GAP(MIN_GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_edge;
  bit          m_idle;
  int          m_gedge;
  int          m_last;
  bit          m_granted;
  int          m_w;
  logic        e_dv;
  logic [N-1:0] e_ready;
  logic [7:0]  e_addr;
  logic        e_side;
  logic [31:0] e_price;
  logic [31:0] e_vol;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_last = N - 1; m_granted = 1'b0; m_w = 0;
    e_dv = 1'b0; e_ready = '0; e_addr = 8'd0; e_side = 1'b0;
    e_price = 32'd0; e_vol = 32'd0;
  endtask

  task automatic chk_outputs(input string pfx);
    chk({pfx, "_dv"},    64'(bus.tx_dv),     64'(e_dv));
    chk({pfx, "_ready"}, 64'(bus.req_ready), 64'(e_ready));
    chk({pfx, "_addr"},  64'(bus.tx_addr),   64'(e_addr));
    chk({pfx, "_side"},  64'(bus.tx_side),   64'(e_side));
    chk({pfx, "_price"}, 64'(bus.tx_price),  64'(e_price));
    chk({pfx, "_vol"},   64'(bus.tx_vol),    64'(e_vol));
  endtask

  task automatic set_order(input int ch, input bit v, input bit side,
                           input logic [31:0] p, input logic [31:0] vol);
    bus.req_valid[ch]          = v;
    bus.req_side[ch]           = side;
    bus.req_price[ch*PW +: PW] = p;
    bus.req_vol[ch*VW +: VW]   = vol;
  endtask

  // One clock: predict from the inputs seen at the edge, then compare.
  task automatic step(input string pfx);
    logic [N-1:0] v;
    bit busy;
    v = bus.req_valid;
    busy = bus.tx_busy;
    m_granted = 1'b0;
    if (m_idle) begin
      if (v != '0 && !busy) begin
        m_w = pick(v, m_last);
        m_last = m_w;
        m_granted = 1'b1;
        m_idle = 1'b0;
        m_gedge = m_edge;
        e_addr = 8'(m_w);
        e_side = bus.req_side[m_w];
        e_price = bus.req_price[m_w*PW +: PW];
        e_vol = bus.req_vol[m_w*VW +: VW];
      end
    end else if (m_edge >= m_gedge + EXIT_MIN && !busy) begin
      m_idle = 1'b1;
    end
    e_dv = m_granted;
    e_ready = '0;
    if (m_granted) e_ready[m_w] = 1'b1;
    m_edge++;
    @(posedge clk);
    #1;
    chk_outputs(pfx);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    reset_n = 1'b1;
  endtask

  int addr_seq[8];
  int cyc_seq[8];
  int ndv;

  initial begin
    checks = 0; failures = 0; m_edge = 0; m_gedge = 0;
    reset_n = 1'b0;
    bus.req_valid = '0; bus.req_side = '0; bus.req_price = '0; bus.req_vol = '0;
    bus.tx_busy = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Fairness: all channels held valid, each presents a new order per grant
    for (int i = 0; i < N; i++) set_order(i, 1'b1, i[0], 32'(16 * i + 1), 32'(i + 5));
    ndv = 0;
    for (int t = 0; t < 40 && ndv < 5; t++) begin
      step("fair");
      if (bus.tx_dv === 1'b1) begin
        addr_seq[ndv] = int'(bus.tx_addr);
        cyc_seq[ndv] = m_edge;
        ndv++;
      end
      if (m_granted) set_order(m_w, 1'b1, ~bus.req_side[m_w], $urandom(), $urandom());
    end
    chk("fair_count", 64'(ndv), 64'd5);
    for (int k = 0; k < ndv; k++) chk("fair_addr", 64'(addr_seq[k]), 64'(k % N));
    for (int k = 1; k < ndv; k++) chk("fair_spacing", 64'(cyc_seq[k] - cyc_seq[k-1]), 64'(SPACING));

    // Reset in the middle of SEND discards the order
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_dv", 64'(bus.tx_dv), 64'd0);
    chk("rstmid_ready", 64'(bus.req_ready), 64'd0);
    chk("rstmid_addr", 64'(bus.tx_addr), 64'd0);
    chk("rstmid_price", 64'(bus.tx_price), 64'd0);
    chk("rstmid_vol", 64'(bus.tx_vol), 64'd0);
    chk("rstmid_side", 64'(bus.tx_side), 64'd0);
    model_reset();
    bus.req_valid = '0;
    @(posedge clk); #1;
    chk_outputs("rstmid_next");
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) step("rst_quiet");

    // Single request on channel 2
    set_order(2, 1'b1, SIDE_SELL, 32'h64, 32'd10);
    step("single");
    chk("single_dv", 64'(bus.tx_dv), 64'd1);
    chk("single_addr", 64'(bus.tx_addr), 64'd2);
    chk("single_side", 64'(bus.tx_side), 64'd1);
    chk("single_price", 64'(bus.tx_price), 64'h64);
    chk("single_vol", 64'(bus.tx_vol), 64'd10);
    chk("single_ready", 64'(bus.req_ready), 64'b0100);
    bus.req_valid = '0;
    step("single_after");
    chk("single_ready_off", 64'(bus.req_ready), 64'd0);

    // Backpressure held for 10 cycles from the first GAP cycle
    set_order(1, 1'b1, SIDE_BUY, 32'h100, 32'd7);
    for (int t = 0; t < 10 && !m_granted; t++) step("bp_wait");
    chk("bp_first_grant", 64'(bus.tx_addr), 64'd1);
    set_order(1, 1'b1, SIDE_SELL, 32'h200, 32'd9);
    step("bp_send");
    bus.tx_busy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step("bp_busy");
      chk("bp_quiet", 64'(bus.tx_dv), 64'd0);
    end
    bus.tx_busy = 1'b0;
    step("bp_rel1");
    chk("bp_rel1_dv", 64'(bus.tx_dv), 64'd0);
    step("bp_rel2");
    chk("bp_rel2_dv", 64'(bus.tx_dv), 64'd1);
    chk("bp_rel2_price", 64'(bus.tx_price), 64'h200);
    bus.req_valid = '0;

    // Wrap: after reset last grant is channel 3; ch0 and ch3 requesting
    do_reset();
    set_order(0, 1'b1, SIDE_BUY, 32'h11, 32'd1);
    set_order(3, 1'b1, SIDE_SELL, 32'h33, 32'd3);
    ndv = 0;
    for (int t = 0; t < 20 && ndv < 2; t++) begin
      step("wrap");
      if (bus.tx_dv === 1'b1) begin
        addr_seq[ndv] = int'(bus.tx_addr);
        ndv++;
      end
      if (m_granted) bus.req_valid[m_w] = 1'b0;
    end
    chk("wrap_count", 64'(ndv), 64'd2);
    chk("wrap_first", 64'(addr_seq[0]), 64'd0);
    chk("wrap_second", 64'(addr_seq[1]), 64'd3);

    // Randomized traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      step("rand");
      if (m_granted) begin
        if ($urandom_range(0, 1) == 0) bus.req_valid[m_w] = 1'b0;
        else set_order(m_w, 1'b1, 1'($urandom()), $urandom(), $urandom());
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
          set_order(i, 1'b1, 1'($urandom()), $urandom(), $urandom());
      end
      bus.tx_busy = ($urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
